alu_logic_bist: RTL

- Self-test sequencer for the 2-bit ALU logic unit. It drives every operand/opcode combination into the unit and reads back the 2-bit result.
- It checks each result against an internal golden model, counts mismatches and reports pass/fail.
- It sits beside the 2-bit ALU and is the response-checking end of its a/b/sel → out interface. It replaces hand-written stimulus sweeps with an on-chip, clocked sweep.

---
 rtl/alu_logic_bist.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_logic_bist.sv
// Clocked self-test sweep for the 2-bit ALU logic unit: drives all 128 {sel,a,b}
// vectors, checks each result against a golden model and reports pass/fail.
module alu_logic_bist #(
    parameter int LAT   = 0,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [1:0]       a_out,
    output logic [1:0]       b_out,
    output logic [2:0]       sel_out,
    input  logic [1:0]       dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [6:0]       first_fail
);

    localparam int WC_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       idx_q, idx_d;
    logic [6:0]       drv_q, drv_d;
    logic [WC_W-1:0]  wait_q, wait_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fv_q, fv_d;
    logic [6:0]       ff_q, ff_d;
    logic             mismatch;

    function automatic logic [1:0] golden(input logic [2:0] s, input logic [1:0] a,
                                          input logic [1:0] b);
        logic [1:0] r;
        case (s)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a & b);
            3'd4:    r = ~(a | b);
            3'd5:    r = ~(a ^ b);
            3'd6:    r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            drv_q   <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drv_q   <= drv_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
        end
    end

    // drv_q is only rewritten in DRIVE, so the operands stay stable through WAIT and CHECK
    assign mismatch = (dut_out != golden(drv_q[6:4], drv_q[3:2], drv_q[1:0]));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drv_d   = drv_q;
        wait_d  = wait_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ff_d    = ff_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    idx_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ff_d    = '0;
                end
            end
            S_DRIVE: begin
                drv_d = idx_q;
                if (LAT == 0) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_WAIT;
                    wait_d  = WC_W'(LAT);
                end
            end
            S_WAIT: begin
                wait_d = wait_q - WC_W'(1);
                if (wait_q <= WC_W'(1)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!fv_q) begin
                        fv_d = 1'b1;
                        ff_d = idx_q;
                    end
                end
                if (idx_q == 7'd127) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 7'd1;
                    state_d = S_DRIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
        done       = (state_q == S_DONE);
        pass       = (state_q == S_DONE) && (err_q == '0);
        err_cnt    = err_q;
        fail_valid = fv_q;
        first_fail = ff_q;
        sel_out    = drv_q[6:4];
        a_out      = drv_q[3:2];
        b_out      = drv_q[1:0];
    end

endmodule
